// File: rtl/pdm_audio_tx.sv
// PCM-to-PDM audio transmitter.
// Samples are buffered in a small FIFO and expanded to OSR bits each by a
// first-order delta-sigma modulator, clocked out at clk/DIV.
module pdm_audio_tx #(
    parameter int DIV   = 50,
    parameter int OSR   = 64,
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic [15:0] sample_data,
    input  logic        sample_valid,
    output logic        sample_ready,
    output logic        pdm_clk,
    output logic        pdm_out,
    output logic        underrun,
    output logic        active
);

    localparam int DW = (DIV   > 1) ? $clog2(DIV)   : 1;
    localparam int OW = (OSR   > 1) ? $clog2(OSR)   : 1;
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;

    logic [15:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          ready_q, ready_d;
    logic          en_q;
    logic [DW-1:0] div_cnt_q, div_cnt_d;
    logic [OW-1:0] bit_cnt_q, bit_cnt_d;
    logic [15:0]   acc_q, acc_d;
    logic [15:0]   cur_q, cur_d;
    logic          pdm_clk_q, pdm_clk_d;
    logic          pdm_out_q, pdm_out_d;
    logic          underrun_q, underrun_d;

    logic          run, tick, load, fifo_empty, push, pop;
    logic [15:0]   u;
    logic [16:0]   sum;

    // Next-state logic for FIFO bookkeeping, bit timing and the modulator.
    // The run qualifier needs both the live and registered enable, so the
    // first enabled edge only arms the block and a falling en clears at once.
    always_comb begin
        run        = en & en_q;
        tick       = run && (div_cnt_q == DW'(DIV - 1));
        load       = tick && (bit_cnt_q == '0);
        fifo_empty = (count_q == '0);
        push       = sample_valid & ready_q;
        pop        = load & ~fifo_empty;

        cur_d = cur_q;
        if (load) begin
            cur_d = fifo_empty ? 16'h0000 : mem[rd_ptr_q];
        end
        u   = cur_d ^ 16'h8000;
        sum = {1'b0, acc_q} + {1'b0, u};

        div_cnt_d = div_cnt_q;
        bit_cnt_d = bit_cnt_q;
        acc_d     = acc_q;
        pdm_out_d = pdm_out_q;
        if (!run) begin
            div_cnt_d = '0;
            bit_cnt_d = '0;
            acc_d     = '0;
            pdm_out_d = 1'b0;
        end else if (tick) begin
            div_cnt_d = '0;
            bit_cnt_d = (bit_cnt_q == OW'(OSR - 1)) ? '0 : bit_cnt_q + OW'(1);
            acc_d     = sum[15:0];
            pdm_out_d = sum[16];
        end else begin
            div_cnt_d = div_cnt_q + DW'(1);
        end

        pdm_clk_d  = run && (div_cnt_d >= DW'(DIV / 2));
        underrun_d = load & fifo_empty;

        wr_ptr_d = wr_ptr_q + AW'(push);
        rd_ptr_d = rd_ptr_q + AW'(pop);
        count_d  = count_q + CW'(push) - CW'(pop);
        ready_d  = (count_d != CW'(DEPTH));
    end

    // State registers; reset clears everything and holds outputs low.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            ready_q    <= 1'b0;
            en_q       <= 1'b0;
            div_cnt_q  <= '0;
            bit_cnt_q  <= '0;
            acc_q      <= '0;
            cur_q      <= '0;
            pdm_clk_q  <= 1'b0;
            pdm_out_q  <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            ready_q    <= ready_d;
            en_q       <= en;
            div_cnt_q  <= div_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            acc_q      <= acc_d;
            cur_q      <= cur_d;
            pdm_clk_q  <= pdm_clk_d;
            pdm_out_q  <= pdm_out_d;
            underrun_q <= underrun_d;
        end
    end

    // FIFO storage; contents need no reset since the pointers gate them.
    always_ff @(posedge clk) begin
        if (!reset && push) begin
            mem[wr_ptr_q] <= sample_data;
        end
    end

    assign sample_ready = ready_q;
    assign pdm_clk      = pdm_clk_q;
    assign pdm_out      = pdm_out_q;
    assign underrun     = underrun_q;
    assign active       = en_q;

endmodule

// File: tb/tb_pdm_audio_tx.sv
// Randomized bench for pdm_audio_tx against a sample-level modulator model.
module tb_pdm_audio_tx;

    localparam int DIV   = 4;
    localparam int OSR   = 8;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        en;
    logic [15:0] sample_data;
    logic        sample_valid;
    logic        sample_ready;
    logic        pdm_clk;
    logic        pdm_out;
    logic        underrun;
    logic        active;

    int total = 0;
    int bad   = 0;

    logic [15:0] mq[$];
    int          model_acc;

    pdm_audio_tx #(.DIV(DIV), .OSR(OSR), .DEPTH(DEPTH)) dut (
        .clk         (clk),
        .reset       (reset),
        .en          (en),
        .sample_data (sample_data),
        .sample_valid(sample_valid),
        .sample_ready(sample_ready),
        .pdm_clk     (pdm_clk),
        .pdm_out     (pdm_out),
        .underrun    (underrun),
        .active      (active)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One output bit of a first-order modulator fed with offset-binary u.
    function automatic bit model_step(input logic [15:0] s);
        int ub;
        ub = int'(s ^ 16'h8000);
        model_acc = model_acc + ub;
        if (model_acc >= 65536) begin
            model_acc = model_acc - 65536;
            return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic push(input logic [15:0] d);
        bit exp_rdy;
        sample_data  = d;
        sample_valid = 1'b1;
        exp_rdy = (mq.size() < DEPTH);
        check("push_ready", sample_ready, exp_rdy);
        if (exp_rdy) mq.push_back(d);
        @(negedge clk);
        sample_valid = 1'b0;
    endtask

    // Enable, collect nbits (one per pdm_clk fall), compare with the model,
    // then disable. An optional held push waits for the first free slot.
    task automatic run_bits(input int nbits, input bit pend, input logic [15:0] pend_data,
                            input string tag);
        int          cyc = 0, got = 0, ur = 0, exp_ur = 0, prev_ur = -1, limit;
        logic        prev_clk = 1'b0, last_bit = 1'b0;
        logic [15:0] cur = 16'h0;
        bit          exp_b, waiting, drop;
        model_acc = 0;
        limit   = (nbits + 3) * DIV + 10;
        waiting = pend;
        drop    = 1'b0;
        if (pend) begin
            sample_data  = pend_data;
            sample_valid = 1'b1;
        end
        en = 1'b1;
        while (got < nbits && cyc < limit) begin
            @(negedge clk);
            cyc++;
            if (drop) begin
                sample_valid = 1'b0;
                drop = 1'b0;
            end
            if (cyc == 1) check($sformatf("%s_active", tag), active, 1);
            if (underrun) begin
                ur++;
                if (prev_ur >= 0) check($sformatf("%s_ur_gap", tag), cyc - prev_ur, OSR * DIV);
                prev_ur = cyc;
            end
            if (prev_clk && !pdm_clk) begin
                if (got == 0) check($sformatf("%s_first_tick", tag), cyc, DIV + 1);
                if (got % OSR == 0) begin
                    if (mq.size() > 0) cur = mq.pop_front();
                    else begin
                        cur = 16'h0000;
                        exp_ur++;
                    end
                end
                exp_b = model_step(cur);
                check($sformatf("%s_bit%0d", tag, got), pdm_out, exp_b);
                last_bit = pdm_out;
                got++;
            end else if (!prev_clk && pdm_clk && got > 0) begin
                check($sformatf("%s_stable%0d", tag, got), pdm_out, last_bit);
            end
            if (waiting) begin
                check($sformatf("%s_hold_ready%0d", tag, cyc), sample_ready, cyc >= DIV + 1);
                if (sample_ready) begin
                    mq.push_back(pend_data);
                    waiting = 1'b0;
                    drop = 1'b1;
                end
            end
            prev_clk = pdm_clk;
        end
        if (got < nbits) check($sformatf("%s_timeout", tag), got, nbits);
        en = 1'b0;
        sample_valid = 1'b0;
        check($sformatf("%s_underruns", tag), ur, exp_ur);
        @(negedge clk);
        @(negedge clk);
        check($sformatf("%s_idle_clk", tag), pdm_clk, 0);
        check($sformatf("%s_idle_out", tag), pdm_out, 0);
    endtask

    initial begin
        logic [15:0] bp [5];
        int          n, falls, guard;

        reset = 1'b1;
        en = 1'b0;
        sample_valid = 1'b0;
        sample_data = 16'h0;
        repeat (3) @(negedge clk);
        check("rst_pdm_clk", pdm_clk, 0);
        check("rst_pdm_out", pdm_out, 0);
        check("rst_underrun", underrun, 0);
        check("rst_active", active, 0);
        check("rst_ready", sample_ready, 0);
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_ready", sample_ready, 1);

        push(16'h0000); run_bits(OSR, 1'b0, 16'h0, "zero");
        push(16'h8000); run_bits(OSR, 1'b0, 16'h0, "negfs");
        push(16'h7FFF); run_bits(OSR, 1'b0, 16'h0, "posfs");

        for (int r = 0; r < 4; r++) begin
            n = $urandom_range(1, DEPTH);
            for (int i = 0; i < n; i++) push(16'($urandom));
            run_bits(n * OSR, 1'b0, 16'h0, $sformatf("rnd%0d", r));
        end

        run_bits(3 * OSR, 1'b0, 16'h0, "under");

        for (int i = 0; i < 5; i++) bp[i] = 16'($urandom);
        for (int i = 0; i < 5; i++) begin
            sample_data  = bp[i];
            sample_valid = 1'b1;
            check($sformatf("bp_ready%0d", i), sample_ready, i < DEPTH);
            if (i < DEPTH) begin
                mq.push_back(bp[i]);
                @(negedge clk);
            end
        end
        repeat (3) begin
            @(negedge clk);
            check("bp_full_hold", sample_ready, 0);
        end
        run_bits(5 * OSR, 1'b1, bp[4], "bp");

        push(16'($urandom));
        push(16'($urandom));
        en = 1'b1;
        falls = 0;
        guard = 0;
        begin
            logic pc = 1'b0;
            while (falls < 3 && guard < 20 * DIV) begin
                @(negedge clk);
                guard++;
                if (pc && !pdm_clk) falls++;
                pc = pdm_clk;
            end
        end
        if (falls < 3) check("mid_timeout", falls, 3);
        reset = 1'b1;
        sample_valid = 1'b1;
        sample_data = 16'h1234;
        @(negedge clk);
        check("mid_rst_pdm_clk", pdm_clk, 0);
        check("mid_rst_pdm_out", pdm_out, 0);
        check("mid_rst_underrun", underrun, 0);
        check("mid_rst_active", active, 0);
        check("mid_rst_ready", sample_ready, 0);
        reset = 1'b0;
        en = 1'b0;
        sample_valid = 1'b0;
        @(negedge clk);
        check("mid_release_ready", sample_ready, 1);
        mq.delete();
        run_bits(OSR, 1'b0, 16'h0, "after_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
